// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg
//   Shared definitions for the FIFO write-side arbiter:
//   - arb_state_t : two-state FSM encoding (ST_IDLE = 0, ST_GRANT = 1)
//   - clog2()     : constant-foldable ceil(log2) used to size the grant
//                   index (IDW) and the per-grant beat counter.
package fifo_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

    // ceil(log2(value)); clog2(1) = 0. Loop bound stays below 31 so the
    // shifted constant never goes negative as a signed int.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick
//   Purely combinational round-robin picker. Scans req starting at
//   last+1 and wrapping modulo NREQ; returns the first set index.
// Ports:
//   req  [NREQ] : request vector
//   last [IDW]  : most recently granted index (scan starts after it)
//   any         : at least one request bit is set
//   idx  [IDW]  : chosen index (0 when any is low)
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last,
    output logic            any,
    output logic [IDW-1:0]  idx
);

    // Walk offsets from farthest to nearest so the closest requester
    // after 'last' is the one that remains assigned.
    always_comb begin
        any = 1'b0;
        idx = '0;
        for (int k = NREQ; k >= 1; k--) begin
            int c;
            c = (int'(last) + k) % NREQ;
            if (req[c]) begin
                any = 1'b1;
                idx = IDW'(c);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Shares the single write port of the dual-clock FIFO among NREQ
//   producers in the write clock domain. Round-robin grant, bounded
//   bursts of up to BURST accepted beats, and wfull backpressure.
// Ports:
//   wclk, wrst        : write clock, synchronous active-high reset
//   req_valid [NREQ]  : per-requester beat present
//   req_data  [NREQ*DSIZE] : requester i data at [i*DSIZE +: DSIZE]
//   req_ready [NREQ]  : one-hot (or zero) beat-accepted strobe
//   wfull             : FIFO full flag (wclk domain)
//   winc, wdata       : FIFO write enable / data
//   gnt_id [IDW]      : current grant holder
//   busy              : FSM is in GRANT (state visibility)
//
// Handshake: a requester's beat transfers in a cycle where both
// req_valid[i] and req_ready[i] are high at the rising edge. req_ready
// depends combinationally on req_valid and wfull; a requester must not
// make req_valid depend on req_ready.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int DSIZE = 8,
    parameter int BURST = 4,
    localparam int IDW  = clog2(NREQ),
    localparam int CW   = clog2(BURST + 1)
) (
    input  logic                  wclk,
    input  logic                  wrst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*DSIZE-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    input  logic                  wfull,
    output logic                  winc,
    output logic [DSIZE-1:0]      wdata,
    output logic [IDW-1:0]        gnt_id,
    output logic                  busy
);

    arb_state_t      r_state;
    arb_state_t      w_state_nxt;
    logic [IDW-1:0]  r_gnt_id;
    logic [IDW-1:0]  r_last;
    logic [CW-1:0]   r_beat_cnt;

    logic            w_any;
    logic [IDW-1:0]  w_pick;
    logic            w_sel_valid;
    logic            w_accept;
    logic            w_last_beat;
    logic            w_release;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req  (req_valid),
        .last (r_last),
        .any  (w_any),
        .idx  (w_pick)
    );

    assign w_sel_valid = req_valid[r_gnt_id];
    // accept is the raw transfer condition; reset masking is applied
    // only on the outputs so registered updates see the same signal.
    assign w_accept    = (r_state == ST_GRANT) && w_sel_valid && !wfull;
    assign w_last_beat = (r_beat_cnt == CW'(BURST - 1));
    // A full stall with valid still high holds the grant indefinitely.
    assign w_release   = (r_state == ST_GRANT) &&
                         ((w_accept && w_last_beat) || !w_sel_valid);

    // State register
    always_ff @(posedge wclk) begin
        if (wrst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_any)     w_state_nxt = ST_GRANT;
            ST_GRANT: if (w_release) w_state_nxt = ST_IDLE;
            default:                 w_state_nxt = ST_IDLE;
        endcase
    end

    // Grant index, round-robin pointer and burst counter
    always_ff @(posedge wclk) begin
        if (wrst) begin
            r_gnt_id   <= '0;
            r_last     <= IDW'(NREQ - 1);
            r_beat_cnt <= '0;
        end else begin
            if (r_state == ST_IDLE && w_any) begin
                r_gnt_id   <= w_pick;
                r_beat_cnt <= '0;
            end
            if (w_accept) begin
                // Wrap on the last beat so the count stays below BURST.
                r_beat_cnt <= w_last_beat ? '0 : r_beat_cnt + 1'b1;
            end
            if (w_release) begin
                r_last <= r_gnt_id;
            end
        end
    end

    // Output logic
    always_comb begin
        req_ready = '0;
        winc      = w_accept && !wrst;
        busy      = (r_state == ST_GRANT) && !wrst;
        gnt_id    = r_gnt_id;
        wdata     = '0;
        if (w_accept && !wrst) begin
            req_ready[r_gnt_id] = 1'b1;
        end
        if (r_state == ST_GRANT) begin
            wdata = req_data[int'(r_gnt_id) * DSIZE +: DSIZE];
        end
    end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Write-side arbiter that shares the single write port of the dual-clock `fifo` among `NREQ` independent producers on the write clock domain. It grants requesters round-robin, holds a grant for a bounded burst of beats, and drives `winc`/`wdata` directly into the FIFO. It honours `wfull` backpressure so no write is issued into a full FIFO.

## Interface
Parameters:
- `NREQ`, 4: number of requesters; must be ≥ 2.
- `DSIZE`, 8: data width; matches the FIFO `DSIZE`.
- `BURST`, 4: maximum accepted beats per grant; must be ≥ 1.

Ports:
- `wclk` input 1: write-domain clock; all state updates on the rising edge.
- `wrst` input 1: synchronous, active-high reset.
- `req_valid` input NREQ: bit i high means requester i presents a beat.
- `req_data` input NREQ*DSIZE: requester i data in bits [i*DSIZE +: DSIZE].
- `req_ready` output NREQ: one-hot or zero; bit i high means requester i's beat is accepted this cycle.
- `wfull` input 1: FIFO full flag in the `wclk` domain.
- `winc` output 1: FIFO write enable.
- `wdata` output DSIZE: FIFO write data.
- `gnt_id` output IDW = $clog2(NREQ): index of the current grant holder.
- `busy` output 1: high while in state GRANT.

## Operation
FSM has two states: IDLE and GRANT.

Registered state:
- `state`.
- `gnt_id`.
- `last`: most recently granted index.
- `beat_cnt`: width $clog2(BURST+1).

IDLE:
- If any `req_valid` is set, select the first set bit scanning `last+1, last+2, …`, wrapping modulo NREQ.
- Register that index into `gnt_id`, clear `beat_cnt`, and go to GRANT.
- If no `req_valid` is set, stay in IDLE.

GRANT:
- `accept = req_valid[gnt_id] & ~wfull`.
- `winc = accept`.
- `req_ready[gnt_id] = accept`; all other `req_ready` bits are 0.
- `wdata = req_data[gnt_id]` in GRANT, otherwise 0.
- On `accept`, `beat_cnt` increments.
- Leave to IDLE and set `last <= gnt_id` when either:
  - `accept` is high and `beat_cnt == BURST-1`, or
  - `req_valid[gnt_id]` is low.
- If `wfull` is high while `req_valid[gnt_id]` is high, the grant is held. No beat is counted and there is no timeout. The requester keeps its place until space frees.

Outputs are combinational from registered state plus `req_valid`, `wfull` and `req_data`. There are no other combinational paths.

Reset (`wrst` high at an edge):
- `state` = IDLE, `gnt_id` = 0, `last` = NREQ-1 (requester 0 wins first), `beat_cnt` = 0.
- While `wrst` is high, `winc`, `req_ready` and `busy` are forced to 0 regardless of state, so a reset mid-burst never writes.

## Timing
- Arbitration latency: `req_valid` seen in IDLE at edge t gives GRANT from t+1. The first `winc` is possible in cycle t+1.
- A burst of k ≤ BURST beats with no backpressure produces k consecutive `winc` cycles.
- Each grant is followed by exactly one IDLE bubble cycle before the next grant.
- Fairness:
  - A continuously requesting requester waits at most (NREQ-1) grants.
  - Ignoring `wfull` stalls, that is at most (NREQ-1)·(BURST+1) cycles.
- Simultaneous events:
  - Valid drop together with a full stall: release to IDLE with no write.
  - `accept` on the last burst beat: the beat is written, then release.
  - `wrst` together with any condition: reset wins.
- `wfull` rising in the same cycle as a write is handled by the FIFO. The arbiter samples `wfull` only combinationally in the current cycle.
- Wrap-around:
  - The pointer scan wraps from NREQ-1 to 0.
  - `beat_cnt` never exceeds BURST-1.

## Structure
- Package `fifo_arb_pkg` holds:
  - the state encoding constants (IDLE = 0, GRANT = 1);
  - the clog2 helper used for IDW and the `beat_cnt` width.
- Sub-module `rr_pick`: purely combinational round-robin picker.
  - Inputs: `req[NREQ]`, `last[IDW]`.
  - Outputs: `any`, `idx[IDW]`.
  - Instantiated once. The FSM, counters and output mux live in `fifo_wr_arbiter`.

## Test plan
- Reset: hold `wrst` for 2 edges with all `req_valid`=4'b1111. Required: `winc`=0, `req_ready`=0, `busy`=0. First grant after release is `gnt_id`=0.
- Round-robin burst: `req_valid`=4'b1111, `wfull`=0, BURST=4, requester i sends 8'h10·i+n. Required:
  - 4 consecutive writes from id 0, one bubble, then 4 from id 1, 2, 3, then 0 again;
  - `wdata` sequence 00,01,02,03,10,11,….
- Short request: only requester 2 valid for 2 cycles. Required: 2 writes of its data, release to IDLE, `last`=2; next grant goes to requester 3 if it is valid.
- Backpressure: `wfull`=1 for 5 cycles mid-burst after 2 beats from requester 1. Required: `winc`=0 and `req_ready`=0 throughout, `gnt_id` held at 1; exactly 2 more beats after `wfull` clears.
- Reset mid-burst: assert `wrst` during the second beat of a grant to requester 3. Required: no `winc` in the reset cycle, state IDLE, next grant to requester 0.
- Valid drop under full: `wfull`=1, requester 0 drops `req_valid`. Required: release with zero writes; the next valid requester (1) is granted after one bubble.
